// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one 32-bit RAM port between instruction fetch (IF) and the
// load/store stage (MEM). One access is granted at a time. The RAM
// request/acknowledge handshake is driven from registered outputs. A
// per-stage pause request is raised while that stage's access is outstanding.
//
// Ports:
//   clk, rst            - clock (rising edge), synchronous active-high reset
//   IfReq_i/IfAddr_i    - IF read request and fetch address
//   IfData_o            - fetched word (live on ack, held afterwards)
//   IfPauseRequest_o    - IF access not yet complete
//   MemReq_i/MemWe_i/MemAddr_i/MemWData_i/MemByteEn_i - MEM access request
//   MemRData_o          - load data (live on ack, held afterwards)
//   MemPauseRequest_o   - MEM access not yet complete
//   Ram*_o              - registered RAM request, write enable, address,
//                         write data and byte enables
//   RamRData_i/RamAck_i - RAM read data and single-cycle completion strobe
//   BusError_o          - one-cycle pulse when an access is aborted by timeout
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT        = 255,
  parameter int unsigned MAX_MEM_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                IfReq_i,
  input  logic [ADDR_W-1:0]   IfAddr_i,
  output logic [DATA_W-1:0]   IfData_o,
  output logic                IfPauseRequest_o,
  input  logic                MemReq_i,
  input  logic                MemWe_i,
  input  logic [ADDR_W-1:0]   MemAddr_i,
  input  logic [DATA_W-1:0]   MemWData_i,
  input  logic [DATA_W/8-1:0] MemByteEn_i,
  output logic [DATA_W-1:0]   MemRData_o,
  output logic                MemPauseRequest_o,
  output logic                RamReq_o,
  output logic                RamWe_o,
  output logic [ADDR_W-1:0]   RamAddr_o,
  output logic [DATA_W-1:0]   RamWData_o,
  output logic [DATA_W/8-1:0] RamByteEn_o,
  input  logic [DATA_W-1:0]   RamRData_i,
  input  logic                RamAck_i,
  output logic                BusError_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned STK_W = $clog2(MAX_MEM_STREAK + 1);

  typedef enum logic [1:0] {
    IDLE,
    IF_ACC,
    MEM_ACC
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cyc_cnt;
  logic [STK_W-1:0]  streak;
  logic [DATA_W-1:0] if_data_q;
  logic [DATA_W-1:0] mem_data_q;

  logic              in_acc;
  logic              timeout;
  logic              acc_done;
  logic              if_end;
  logic              mem_end;
  logic              if_live;
  logic              mem_live;
  logic [DATA_W-1:0] rd_word;
  logic              grant_mem;
  logic              grant_if;

  always_comb begin
    in_acc   = (state != IDLE);
    // cyc_cnt counts completed ack-less ACC cycles, so this is the
    // TIMEOUT-th ACC cycle without an ack.
    timeout  = in_acc && !RamAck_i && (cyc_cnt == CNT_W'(TIMEOUT - 1));
    acc_done = in_acc && (RamAck_i || timeout);
    if_end   = (state == IF_ACC) && acc_done;
    mem_end  = (state == MEM_ACC) && acc_done;
    // A withdrawn requester (flush) and MEM writes do not take read data.
    if_live  = !rst && if_end && IfReq_i;
    mem_live = !rst && mem_end && MemReq_i && !RamWe_o;
    // A timed-out read returns zero.
    rd_word  = RamAck_i ? RamRData_i : '0;

    IfData_o          = if_live  ? rd_word : if_data_q;
    MemRData_o        = mem_live ? rd_word : mem_data_q;
    IfPauseRequest_o  = !rst && IfReq_i  && !if_end;
    MemPauseRequest_o = !rst && MemReq_i && !mem_end;
    BusError_o        = !rst && timeout;

    // MEM wins ties unless IF has already waited out MAX_MEM_STREAK grants.
    grant_mem = MemReq_i && (!IfReq_i || (streak != STK_W'(MAX_MEM_STREAK)));
    grant_if  = IfReq_i && !grant_mem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cyc_cnt     <= '0;
      streak      <= '0;
      if_data_q   <= '0;
      mem_data_q  <= '0;
      RamReq_o    <= 1'b0;
      RamWe_o     <= 1'b0;
      RamAddr_o   <= '0;
      RamWData_o  <= '0;
      RamByteEn_o <= '0;
    end else begin
      if (if_live)  if_data_q  <= rd_word;
      if (mem_live) mem_data_q <= rd_word;

      case (state)
        IDLE: begin
          cyc_cnt <= '0;
          if (grant_mem) begin
            state       <= MEM_ACC;
            RamReq_o    <= 1'b1;
            RamWe_o     <= MemWe_i;
            RamAddr_o   <= MemAddr_i;
            RamWData_o  <= MemWData_i;
            RamByteEn_o <= MemByteEn_i;
            streak      <= IfReq_i ? streak + 1'b1 : '0;
          end else if (grant_if) begin
            state       <= IF_ACC;
            RamReq_o    <= 1'b1;
            RamWe_o     <= 1'b0;
            RamAddr_o   <= IfAddr_i;
            RamWData_o  <= '0;
            RamByteEn_o <= '1;
            streak      <= '0;
          end else begin
            // Only reached with IfReq_i low.
            streak <= '0;
          end
        end
        default: begin
          if (acc_done) begin
            state    <= IDLE;
            RamReq_o <= 1'b0;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios followed by randomized
// traffic, all checked every cycle against a transaction-level reference
// model (who owns the bus, how long it has waited, how many MEM grants IF
// has sat through).
module tb_mem_bus_arbiter;

  localparam int TMO  = 255;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_pause;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_pause;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic [31:0] ram_rdata;
  logic        ram_ack;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT(TMO),
    .MAX_MEM_STREAK(MAXS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .IfReq_i(if_req),
    .IfAddr_i(if_addr),
    .IfData_o(if_data),
    .IfPauseRequest_o(if_pause),
    .MemReq_i(mem_req),
    .MemWe_i(mem_we),
    .MemAddr_i(mem_addr),
    .MemWData_i(mem_wdata),
    .MemByteEn_i(mem_be),
    .MemRData_o(mem_rdata),
    .MemPauseRequest_o(mem_pause),
    .RamReq_o(ram_req),
    .RamWe_o(ram_we),
    .RamAddr_o(ram_addr),
    .RamWData_o(ram_wdata),
    .RamByteEn_o(ram_be),
    .RamRData_i(ram_rdata),
    .RamAck_i(ram_ack),
    .BusError_o(bus_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model. owner: 0 = bus free, 1 = IF, 2 = MEM.
  int          m_owner;
  int          m_waited;
  int          m_streak;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_if_q;
  logic [31:0] m_mem_q;
  logic        e_done;
  logic        e_if_live;
  logic        e_mem_live;
  logic [31:0] e_word;

  task automatic model_reset();
    m_owner  = 0;
    m_waited = 0;
    m_streak = 0;
    m_addr   = '0;
    m_wdata  = '0;
    m_we     = 1'b0;
    m_be     = '0;
    m_if_q   = '0;
    m_mem_q  = '0;
  endtask

  // Inputs are settled; compare every output with the model's prediction.
  task automatic eval();
    logic tmo;
    #1;
    tmo        = (m_owner != 0) && !ram_ack && (m_waited == TMO - 1);
    e_done     = (m_owner != 0) && (ram_ack || tmo);
    e_word     = ram_ack ? ram_rdata : 32'h0;
    e_if_live  = !rst && (m_owner == 1) && e_done && if_req;
    e_mem_live = !rst && (m_owner == 2) && e_done && mem_req && !m_we;
    chk("if_data",   if_data,   e_if_live ? e_word : m_if_q);
    chk("mem_rdata", mem_rdata, e_mem_live ? e_word : m_mem_q);
    chk("if_pause",  if_pause,  32'(!rst && if_req && !((m_owner == 1) && e_done)));
    chk("mem_pause", mem_pause, 32'(!rst && mem_req && !((m_owner == 2) && e_done)));
    chk("bus_err",   bus_err,   32'(!rst && tmo));
    chk("ram_req",   ram_req,   32'(m_owner != 0));
    chk("ram_we",    ram_we,    32'(m_we));
    chk("ram_addr",  ram_addr,  m_addr);
    chk("ram_wdata", ram_wdata, m_wdata);
    chk("ram_be",    ram_be,    32'(m_be));
  endtask

  // Advance the model over the coming clock edge, then move to the next
  // falling edge where new inputs are applied.
  task automatic tick();
    if (rst) begin
      model_reset();
    end else begin
      if (e_if_live)  m_if_q  = e_word;
      if (e_mem_live) m_mem_q = e_word;
      if (m_owner != 0) begin
        if (e_done) m_owner = 0;
        else        m_waited++;
      end else if (mem_req && (!if_req || m_streak < MAXS)) begin
        m_owner  = 2;
        m_waited = 0;
        m_addr   = mem_addr;
        m_wdata  = mem_wdata;
        m_we     = mem_we;
        m_be     = mem_be;
        m_streak = if_req ? m_streak + 1 : 0;
      end else if (if_req) begin
        m_owner  = 1;
        m_waited = 0;
        m_addr   = if_addr;
        m_wdata  = '0;
        m_we     = 1'b0;
        m_be     = 4'hF;
        m_streak = 0;
      end else begin
        m_streak = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req  = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ram_ack = 1'b0;
  endtask

  int grants[$];
  int exp_order[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
  logic prev_req;
  int hi_cycles;
  int err_pulses;
  logic drop_mem;

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_be = '0;
    ram_rdata = '0; ram_ack = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);

    // Reset state: pauses forced low even with both stages requesting.
    if_req = 1'b1; mem_req = 1'b1;
    eval();
    chk("rst_pause_if", if_pause, 0);
    chk("rst_ram_req", ram_req, 0);
    tick();
    rst = 1'b0;
    idle_inputs();
    eval(); tick();

    // IF only, zero-wait RAM.
    if_req = 1'b1; if_addr = 32'h100;
    eval();
    chk("t1_pause_c0", if_pause, 1);
    tick();
    ram_ack = 1'b1; ram_rdata = 32'h24010005;
    eval();
    chk("t1_addr", ram_addr, 32'h100);
    chk("t1_req", ram_req, 1);
    chk("t1_data_live", if_data, 32'h24010005);
    chk("t1_pause_c1", if_pause, 0);
    tick();
    idle_inputs(); ram_rdata = 32'h0;
    eval();
    chk("t1_data_held", if_data, 32'h24010005);
    chk("t1_req_drop", ram_req, 0);
    tick();
    eval(); tick();

    // Both request together: MEM write first, then IF after a turnaround.
    if_req = 1'b1; if_addr = 32'h40;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h2000;
    mem_wdata = 32'hDEADBEEF; mem_be = 4'b0011;
    eval(); tick();
    ram_ack = 1'b1;
    eval();
    chk("t2_we", ram_we, 1);
    chk("t2_be", ram_be, 32'h3);
    chk("t2_addr", ram_addr, 32'h2000);
    chk("t2_wdata", ram_wdata, 32'hDEADBEEF);
    chk("t2_if_wait", if_pause, 1);
    tick();
    mem_req = 1'b0; mem_we = 1'b0; ram_ack = 1'b0;
    eval();
    chk("t2_if_wait_idle", if_pause, 1);
    tick();
    ram_ack = 1'b1; ram_rdata = 32'h13579BDF;
    eval();
    chk("t2_if_addr", ram_addr, 32'h40);
    chk("t2_if_be", ram_be, 32'hF);
    chk("t2_if_pause", if_pause, 0);
    tick();
    idle_inputs();
    eval(); tick();

    // MEM back-to-back with IF held: streak limit forces an IF grant.
    grants.delete();
    prev_req = 1'b0;
    if_req = 1'b1; if_addr = 32'h1000;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h3000;
    ram_ack = 1'b1;
    for (int c = 0; c < 60 && grants.size() < 10; c++) begin
      ram_rdata = $urandom;
      eval();
      if (ram_req === 1'b1 && prev_req === 1'b0)
        grants.push_back((ram_addr === 32'h1000) ? 1 : 2);
      prev_req = ram_req;
      tick();
    end
    chk("t3_grant_count", grants.size(), 10);
    for (int i = 0; i < 10; i++)
      if (i < grants.size()) chk($sformatf("t3_grant%0d", i), grants[i], exp_order[i]);
    idle_inputs();
    eval(); tick();
    eval(); tick();

    // IF withdraws mid-access: access completes, no capture, pause low.
    if_req = 1'b1; if_addr = 32'h600;
    ram_ack = 1'b1; ram_rdata = 32'h11112222;
    eval(); tick();
    eval(); tick();
    if_req = 1'b0; ram_ack = 1'b0;
    eval(); tick();
    if_req = 1'b1; if_addr = 32'h604;
    eval(); tick();
    if_req = 1'b0;
    eval();
    chk("t4_pause", if_pause, 0);
    tick();
    ram_ack = 1'b1; ram_rdata = 32'h99999999;
    eval();
    chk("t4_still_req", ram_req, 1);
    chk("t4_no_capture", if_data, 32'h11112222);
    chk("t4_pause_ack", if_pause, 0);
    tick();
    ram_ack = 1'b0;
    eval();
    chk("t4_held", if_data, 32'h11112222);
    tick();

    // Timeout on a MEM read, after priming the load data with a value.
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40;
    ram_ack = 1'b1; ram_rdata = 32'hCAFEF00D;
    eval(); tick();
    eval(); tick();
    mem_req = 1'b0; ram_ack = 1'b0;
    eval(); tick();
    mem_req = 1'b1; mem_addr = 32'h44;
    hi_cycles = 0; err_pulses = 0; drop_mem = 1'b0;
    for (int c = 0; c < 262; c++) begin
      eval();
      if (ram_req === 1'b1) hi_cycles++;
      if (bus_err === 1'b1) err_pulses++;
      if (ram_req === 1'b1 && mem_pause === 1'b0) drop_mem = 1'b1;
      tick();
      if (drop_mem) mem_req = 1'b0;
    end
    chk("t5_req_cycles", hi_cycles, TMO);
    chk("t5_err_pulses", err_pulses, 1);
    eval();
    chk("t5_rdata_zero", mem_rdata, 0);
    tick();

    // Reset in the 3rd cycle of a 5-wait-state access; late ack ignored.
    if_req = 1'b1; if_addr = 32'h500;
    eval(); tick();
    eval(); tick();
    eval(); tick();
    rst = 1'b1;
    eval(); tick();
    rst = 1'b0; if_req = 1'b0;
    ram_ack = 1'b1; ram_rdata = 32'h77777777;
    eval();
    chk("t6_req", ram_req, 0);
    chk("t6_if_data", if_data, 0);
    chk("t6_pause", if_pause, 0);
    chk("t6_addr", ram_addr, 0);
    tick();
    ram_ack = 1'b0;
    eval();
    chk("t6_no_capture", if_data, 0);
    tick();

    // Randomized traffic with sticky requests, rare resets and flushes.
    for (int c = 0; c < 2000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) if_req  = ~if_req;
      if ($urandom_range(0, 3) == 0) mem_req = ~mem_req;
      if_addr   = $urandom;
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      mem_we    = $urandom_range(0, 1);
      mem_be    = 4'($urandom_range(0, 15));
      ram_ack   = ($urandom_range(0, 2) == 0);
      ram_rdata = $urandom;
      eval();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
